// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, FSM states, request payload.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_DATA_W = 32;
    localparam int unsigned OP_W       = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_ADD     = 3'b010,
        OP_ILLEGAL = 3'b011,
        OP_NOR     = 3'b100,
        OP_XOR     = 3'b101,
        OP_SUB     = 3'b110,
        OP_MUL     = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        alu_op_e               op;
        logic                  unsig;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, add/sub/mul with signed or unsigned overflow detection.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W
)(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              unsig,
    output logic [DATA_W-1:0] aluout,
    output logic              overflow
);

    localparam int unsigned MSB  = DATA_W - 1;
    localparam int unsigned PW   = 2 * DATA_W;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [PW-1:0]   ext_a;
    logic [PW-1:0]   ext_b;
    logic [PW-1:0]   prod;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    // Sign- or zero-extend so the low 2*DATA_W bits hold the exact product.
    assign ext_a = {{DATA_W{a[MSB] & ~unsig}}, a};
    assign ext_b = {{DATA_W{b[MSB] & ~unsig}}, b};
    assign prod  = ext_a * ext_b;

    always_comb begin
        aluout   = '0;
        overflow = 1'b0;
        case (op)
            OP_AND: aluout = a & b;
            OP_OR:  aluout = a | b;
            OP_NOR: aluout = ~(a | b);
            OP_XOR: aluout = a ^ b;
            OP_ADD: begin
                aluout   = sum[MSB:0];
                overflow = unsig ? sum[DATA_W]
                                 : ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]));
            end
            OP_SUB: begin
                aluout   = diff[MSB:0];
                overflow = unsig ? diff[DATA_W]
                                 : ((a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]));
            end
            OP_MUL: begin
                aluout   = prod[MSB:0];
                overflow = unsig ? (|prod[PW-1:DATA_W])
                                 : (prod[PW-1:DATA_W] != {DATA_W{prod[MSB]}});
            end
            default: aluout = sum[MSB:0];
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
)(
    input  logic [NREQ-1:0]  req_valid,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             grant_vld_c,
    output logic [PTR_W-1:0] grant_idx_c
);

    logic [PTR_W-1:0] idx;

    // Scan from farthest to nearest so the requester closest to rr_ptr wins.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        idx         = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(rr_ptr) + k) % int'(NREQ));
            if (req_valid[idx]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters with round-robin arbitration and per-owner responses.
// Define ALU_ARB_MUL_MULTICYCLE_EN to give MUL 1+MUL_CYCLES EXEC cycles.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned MUL_CYCLES = 2
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ALU_DATA_W-1:0] req_a,
    input  logic [NREQ*ALU_DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]       req_op,
    input  logic [NREQ-1:0]            req_unsig,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [ALU_DATA_W-1:0]      rsp_data,
    output logic                       rsp_overflow,
    output logic                       rsp_illegal,
    output logic                       busy
);

    localparam int unsigned DATA_W = ALU_DATA_W;
    localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q;
    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  owner_q;
    alu_req_t          opnd_q;
    alu_req_t          sel_req;
    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic              accept;
    logic              exec_done;
    logic              ill_op;
    logic [DATA_W-1:0] alu_y;
    logic              alu_ovf;

    logic [DATA_W-1:0] a_arr  [NREQ];
    logic [DATA_W-1:0] b_arr  [NREQ];
    logic [OP_W-1:0]   op_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
        assign op_arr[i] = req_op[i*OP_W +: OP_W];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant_vld_c (grant_vld),
        .grant_idx_c (grant_idx)
    );

    always_comb begin
        sel_req       = '0;
        sel_req.a     = a_arr[grant_idx];
        sel_req.b     = b_arr[grant_idx];
        sel_req.op    = alu_op_e'(op_arr[grant_idx]);
        sel_req.unsig = req_unsig[grant_idx];
    end

    assign accept    = (state_q == ST_IDLE) && grant_vld && !reset;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;
    assign ill_op    = (opnd_q.op == OP_ILLEGAL);

    // The ALU only ever sees the registered operands.
    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (opnd_q.a),
        .b        (opnd_q.b),
        .op       (opnd_q.op),
        .unsig    (opnd_q.unsig),
        .aluout   (alu_y),
        .overflow (alu_ovf)
    );

`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam int unsigned CNT_W = (MUL_CYCLES < 1) ? 1 : $clog2(MUL_CYCLES + 1);

    logic [CNT_W-1:0] exec_cnt_q;

    // Remaining extra EXEC cycles; loaded on acceptance, non-zero only for MUL.
    always_ff @(posedge clock) begin
        if (reset) begin
            exec_cnt_q <= '0;
        end else if (accept) begin
            exec_cnt_q <= (sel_req.op == OP_MUL) ? CNT_W'(MUL_CYCLES) : '0;
        end else if ((state_q == ST_EXEC) && (exec_cnt_q != '0)) begin
            exec_cnt_q <= exec_cnt_q - CNT_W'(1);
        end
    end

    assign exec_done = (exec_cnt_q == '0);
`else
    // Every op completes in a single EXEC cycle in this build.
    assign exec_done = 1'b1 || (MUL_CYCLES != 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            opnd_q       <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            rsp_illegal  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        opnd_q  <= sel_req;
                        owner_q <= grant_idx;
                        busy    <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        // Illegal op leaves the ALU output meaningless, so it is zeroed.
                        rsp_data     <= ill_op ? '0 : alu_y;
                        rsp_overflow <= !ill_op && alu_ovf;
                        rsp_illegal  <= ill_op;
                        rsp_valid    <= NREQ'(1) << owner_q;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid <= '0;
                        rr_ptr_q  <= (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);
                        busy      <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases plus randomized traffic against a transaction-level model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int W    = 32;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    localparam int MUL_EXTRA = 2;
`else
    localparam int MUL_EXTRA = 0;
`endif
    localparam int LAT     = 2;
    localparam int MUL_LAT = 2 + MUL_EXTRA;
    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    typedef logic [NREQ*W-1:0] bus_t;
    typedef logic [NREQ*3-1:0] opbus_t;
    typedef logic [NREQ-1:0]   vec_t;

    logic          clock;
    logic          reset;
    vec_t          req_valid;
    vec_t          req_ready;
    bus_t          req_a;
    bus_t          req_b;
    opbus_t        req_op;
    vec_t          req_unsig;
    vec_t          rsp_valid;
    vec_t          rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_overflow;
    logic          rsp_illegal;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_arbiter #(
        .NREQ       (NREQ),
        .MUL_CYCLES (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .req_unsig    (req_unsig),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_overflow (rsp_overflow),
        .rsp_illegal  (rsp_illegal),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic bit_at(input vec_t v, input int i);
        return 1'(v >> i);
    endfunction

    // Reference ALU from plain signed 64-bit arithmetic.
    function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                    output logic [31:0] d, output logic ov, output logic il);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        d  = '0;
        ov = 1'b0;
        il = 1'b0;
        case (op)
            3'b000: d = a & b;
            3'b001: d = a | b;
            3'b100: d = ~(a | b);
            3'b101: d = a ^ b;
            3'b011: il = 1'b1;
            3'b010: r = sa + sb;
            3'b110: r = sa - sb;
            default: r = sa * sb;
        endcase
        if (op == 3'b010 || op == 3'b110 || op == 3'b111) begin
            d  = r[31:0];
            ov = (r > S_MAX) || (r < S_MIN);
        end
    endfunction

    // Transaction-level model: who gets granted, when the response shows, what it carries.
    int          cyc = 0;
    bit          m_act = 0;
    int          m_owner = 0;
    int          m_rr = 0;
    int          m_done_at = 0;
    logic [31:0] m_d;
    logic        m_o;
    logic        m_i;
    bit          m_chk_d;

    always @(negedge clock) begin
        vec_t        e_rdy;
        vec_t        e_rv;
        logic        e_busy;
        int          g;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [2:0]  fop;
        cyc++;
        e_rdy  = '0;
        e_rv   = '0;
        e_busy = 1'b0;
        g      = -1;
        if (reset) begin
            m_act = 0;
            m_rr  = 0;
        end else begin
            if (!m_act) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (g < 0 && bit_at(req_valid, (m_rr + k) % NREQ)) g = (m_rr + k) % NREQ;
                end
                if (g >= 0) begin
                    fa  = 32'(req_a >> (g * W));
                    fb  = 32'(req_b >> (g * W));
                    fop = 3'(req_op >> (g * 3));
                    e_rdy     = vec_t'(1) << g;
                    m_act     = 1;
                    m_owner   = g;
                    m_done_at = cyc + 2 + ((fop == 3'b111) ? MUL_EXTRA : 0);
                    ref_alu(fa, fb, fop, m_d, m_o, m_i);
                    m_chk_d   = !(fop == 3'b111 && m_o);
                end
            end else begin
                e_busy = 1'b1;
                if (cyc >= m_done_at) begin
                    e_rv = vec_t'(1) << m_owner;
                    if (bit_at(rsp_valid, m_owner)) begin
                        if (m_chk_d) chk("model_rsp_data", 64'(rsp_data), 64'(m_d));
                        chk("model_rsp_overflow", 64'(rsp_overflow), 64'(m_o));
                        chk("model_rsp_illegal", 64'(rsp_illegal), 64'(m_i));
                    end
                    if (bit_at(rsp_ready, m_owner)) begin
                        m_act = 0;
                        m_rr  = (m_owner + 1) % NREQ;
                    end
                end
            end
            chk("model_req_ready", 64'(req_ready), 64'(e_rdy));
            chk("model_rsp_valid", 64'(rsp_valid), 64'(e_rv));
            chk("model_busy", 64'(busy), 64'(e_busy));
        end
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a     = (req_a & ~(bus_t'({W{1'b1}}) << (i * W))) | (bus_t'(a) << (i * W));
        req_b     = (req_b & ~(bus_t'({W{1'b1}}) << (i * W))) | (bus_t'(b) << (i * W));
        req_op    = (req_op & ~(opbus_t'(3'b111) << (i * 3))) | (opbus_t'(op) << (i * 3));
        req_valid = req_valid | (vec_t'(1) << i);
    endtask

    task automatic clr_req(input int i);
        req_valid = req_valid & ~(vec_t'(1) << i);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int w = 0; w < 10 && !ok; w++) begin
            @(negedge clock);
            if (req_ready != '0) ok = 1;
        end
        if (!ok) chk("timeout_req_ready", 64'(req_ready), 64'(1));
    endtask

    task automatic wait_rsp(output bit ok, output int lat);
        ok  = 0;
        lat = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clock);
            lat++;
            if (rsp_valid != '0) ok = 1;
        end
        if (!ok) chk("timeout_rsp_valid", 64'(rsp_valid), 64'(1));
    endtask

    task automatic run_op(input string nm, input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int exp_lat, input logic [31:0] ed,
                          input logic eo, input logic ei, input bit chk_d);
        bit ok;
        int lat;
        @(posedge clock);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        set_req(i, a, b, op);
        wait_ready(ok);
        if (ok) chk({nm, "_grant"}, 64'(req_ready), 64'(vec_t'(1) << i));
        @(posedge clock);
        #1;
        req_valid = '0;
        wait_rsp(ok, lat);
        if (ok) begin
            chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
            chk({nm, "_owner"}, 64'(rsp_valid), 64'(vec_t'(1) << i));
            if (chk_d) chk({nm, "_data"}, 64'(rsp_data), 64'(ed));
            chk({nm, "_overflow"}, 64'(rsp_overflow), 64'(eo));
            chk({nm, "_illegal"}, 64'(rsp_illegal), 64'(ei));
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: begin
                case ($urandom_range(0, 4))
                    0: return 32'h0000_0000;
                    1: return 32'h0000_0001;
                    2: return 32'h7FFF_FFFF;
                    3: return 32'h8000_0000;
                    default: return 32'hFFFF_FFFF;
                endcase
            end
            1: return 32'($urandom_range(0, 40)) - 32'd20;
            2: return 32'($urandom_range(0, 65535));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        bit   ok;
        int   lat;
        vec_t rdy;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_unsig = '0;
        rsp_ready = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        @(negedge clock);
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_rsp_data", 64'(rsp_data), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));

        run_op("add_basic", 0, 32'd5, 32'd7, 3'b010, LAT, 32'd12, 1'b0, 1'b0, 1);
        run_op("add_ovf", 1, 32'h7FFF_FFFF, 32'd1, 3'b010, LAT, 32'h8000_0000, 1'b1, 1'b0, 1);
        run_op("sub_ovf", 1, 32'h8000_0000, 32'd1, 3'b110, LAT, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run_op("mul_ovf", 0, 32'h0001_0000, 32'h0001_0000, 3'b111, MUL_LAT, 32'd0, 1'b1, 1'b0, 0);
        run_op("mul_neg", 0, 32'hFFFF_FFFD, 32'd4, 3'b111, MUL_LAT, 32'hFFFF_FFF4, 1'b0, 1'b0, 1);
        run_op("illegal", 1, 32'h1234, 32'h5678, 3'b011, LAT, 32'd0, 1'b0, 1'b1, 1);

        // Both requesters always pending from rr_ptr=0: grants must alternate 0,1,0.
        do_reset();
        @(posedge clock);
        #1;
        rsp_ready = '1;
        set_req(0, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b000);
        set_req(1, 32'h1234_5678, 32'hFFFF_0000, 3'b000);
        for (int t = 0; t < 3; t++) begin
            wait_ready(ok);
            if (ok) chk("arb_grant", 64'(req_ready), 64'((t == 1) ? 2'b10 : 2'b01));
            wait_rsp(ok, lat);
            if (ok) chk("arb_owner_rsp", 64'(rsp_valid), 64'((t == 1) ? 2'b10 : 2'b01));
        end
        @(posedge clock);
        #1;
        req_valid = '0;

        // Backpressure: response held while the owner is not ready.
        @(posedge clock);
        #1;
        rsp_ready = '0;
        set_req(0, 32'd100, 32'd23, 3'b010);
        wait_ready(ok);
        @(posedge clock);
        #1;
        req_valid = 2'b10;
        wait_rsp(ok, lat);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
            chk("bp_rsp_data", 64'(rsp_data), 64'(123));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clock);
        #1;
        rsp_ready = 2'b01;
        req_valid = '0;
        @(negedge clock);
        chk("bp_release_valid", 64'(rsp_valid), 64'(2'b01));
        @(negedge clock);
        chk("bp_after_valid", 64'(rsp_valid), 64'(0));
        chk("bp_after_busy", 64'(busy), 64'(0));

        // Reset while the operation is in EXEC drops it.
        @(posedge clock);
        #1;
        rsp_ready = '1;
        set_req(0, 32'd50, 32'd8, 3'b110);
        wait_ready(ok);
        @(posedge clock);
        #1;
        reset     = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_exec_req_ready", 64'(req_ready), 64'(0));
        chk("rst_exec_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_exec_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_exec_overflow", 64'(rsp_overflow), 64'(0));
        chk("rst_exec_illegal", 64'(rsp_illegal), 64'(0));
        chk("rst_exec_busy", 64'(busy), 64'(0));
        repeat (4) begin
            @(negedge clock);
            chk("rst_exec_no_rsp", 64'(rsp_valid), 64'(0));
        end

        // Randomized traffic; second half with rsp_ready tied high.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            rdy = req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (bit_at(req_valid, i) && bit_at(rdy, i)) begin
                    if ($urandom_range(0, 3) != 0) set_req(i, rand_word(), rand_word(), 3'($urandom_range(0, 7)));
                    else clr_req(i);
                end else if (!bit_at(req_valid, i)) begin
                    if ($urandom_range(0, 2) == 0) set_req(i, rand_word(), rand_word(), 3'($urandom_range(0, 7)));
                end else if ($urandom_range(0, 15) == 0) begin
                    clr_req(i);
                end
            end
            rsp_ready = (c >= 1500) ? '1 : vec_t'($urandom);
        end

        @(posedge clock);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        repeat (10) @(negedge clock);
        chk("drain_busy", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
